// File: rtl/mem_test_pkg.sv
// rtl/mem_test_pkg.sv - shared defaults and address helper for memory_tester
package mem_test_pkg;

  localparam int ADDR_SIZE_DEF = 16;
  localparam int WORD_SIZE_DEF = 16;
  localparam int DEPTH_DEF     = 2;

  localparam logic [WORD_SIZE_DEF-1:0] EXPECTED_ONES = '1;

  // Address is carried at 64 bits so any ADDR_SIZE up to 64 compares without truncation.
  function automatic logic in_range(input logic [63:0] addr, input int unsigned depth);
    return addr < 64'(depth);
  endfunction

endpackage

// File: rtl/mem_word_cell.sv
// rtl/mem_word_cell.sv - one stored word plus a flag saying it holds the expected pattern
module mem_word_cell #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] EXPECTED  = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [WORD_SIZE-1:0] d,
  output logic [WORD_SIZE-1:0] q,
  output logic                 match
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      match <= 1'b0;
    end else if (we) begin
      q     <= d;
      match <= (d == EXPECTED);
    end
  end

endmodule

// File: rtl/memory_tester.sv
// rtl/memory_tester.sv - small bus-target RAM that flags when every word holds EXPECTED
module memory_tester
  import mem_test_pkg::*;
#(
  parameter int                   ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int                   WORD_SIZE = WORD_SIZE_DEF,
  parameter int                   DEPTH     = DEPTH_DEF,
  parameter logic [WORD_SIZE-1:0] EXPECTED  = EXPECTED_ONES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  input  logic                 write_en,
  output logic                 content_ok
);

  logic [63:0]          addr_ext;
  logic                 addr_ok;
  logic [DEPTH-1:0]     we_vec;
  logic [DEPTH-1:0]     match;
  logic [DEPTH-1:0]     match_next;
  logic [WORD_SIZE-1:0] q [DEPTH];
  logic [WORD_SIZE-1:0] rd_word;

  assign addr_ext = 64'(addr);
  assign addr_ok  = in_range(addr_ext, DEPTH);

  // Decode and read mux share the same compare; out-of-range reads fall through to zero.
  always_comb begin
    we_vec  = '0;
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_ok && (addr_ext == 64'(i))) begin
        we_vec[i] = write_en;
        rd_word   = q[i];
      end
    end
  end

  // Apply this cycle's write to the flags so content_ok tracks the edge that changes them.
  always_comb begin
    match_next = match;
    for (int i = 0; i < DEPTH; i++) begin
      if (we_vec[i]) match_next[i] = (data_in == EXPECTED);
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      mem_word_cell #(
        .WORD_SIZE (WORD_SIZE),
        .EXPECTED  (EXPECTED)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .we    (we_vec[g]),
        .d     (data_in),
        .q     (q[g]),
        .match (match[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      content_ok <= 1'b0;
    end else begin
      data_out   <= rd_word;
      content_ok <= &match_next;
    end
  end

endmodule

// File: tb/tb_memory_tester.sv
// tb/tb_memory_tester.sv - scoreboard bench for memory_tester with a word-array reference model
module tb_memory_tester;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        write_en = 1'b0;
  logic        content_ok;

  typedef struct {
    logic [15:0] dout;
    logic        ok;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_mem [DEPTH];
  int          n_tests = 0;
  int          n_fail  = 0;

  memory_tester dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .write_en   (write_en),
    .content_ok (content_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic all_expected();
    for (int i = 0; i < DEPTH; i++)
      if (model_mem[i] != 16'hFFFF) return 1'b0;
    return 1'b1;
  endfunction

  // One bus cycle: drive inputs, record what the next edge must produce.
  task automatic cycle(input logic we, input int unsigned a, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    write_en = we;
    addr     = a[15:0];
    data_in  = d;
    e.dout   = (a < DEPTH) ? model_mem[a] : 16'h0000;
    if (we && a < DEPTH) model_mem[a] = d;
    e.ok     = all_expected();
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    write_en = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    #1;
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_content_ok", 32'(content_ok), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.dout));
        check("content_ok", 32'(content_ok), 32'(e.ok));
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    #1;
    check("por_data_out", 32'(data_out), 32'h0);
    check("por_content_ok", 32'(content_ok), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    cycle(1'b0, 0, 16'h0);
    cycle(1'b0, 1, 16'h0);
    cycle(1'b1, 0, 16'hFFFF);
    cycle(1'b1, 1, 16'hFFFF);
    cycle(1'b0, 0, 16'h0);
    cycle(1'b0, 1, 16'h0);
    cycle(1'b1, 0, 16'h1234);
    cycle(1'b0, 0, 16'h0);
    cycle(1'b1, 0, 16'hFFFF);
    cycle(1'b1, 5, 16'hFFFF);
    cycle(1'b0, 5, 16'h0);
    cycle(1'b0, 0, 16'h0);
    cycle(1'b1, 1, 16'hAAAA);
    cycle(1'b0, 1, 16'h0);
    cycle(1'b1, 1, 16'hFFFF);
    cycle(1'b1, 1, 16'hFFFF);
    cycle(1'b0, 0, 16'h0);
    do_reset();
    cycle(1'b0, 0, 16'h0);
    cycle(1'b0, 1, 16'h0);

    for (int n = 0; n < 400; n++) begin
      int unsigned a;
      logic [15:0] d;
      case ($urandom_range(0, 7))
        0:       a = 16'hFFFF;
        1:       a = $urandom_range(2, 9);
        default: a = $urandom_range(0, DEPTH - 1);
      endcase
      d = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle($urandom_range(0, 2) != 0, a, d);
    end

    @(negedge clk);
    write_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
